// File: rtl/multicycle_alu.sv
// Registered ALU stage behind the ALU control decoder.
// Logic and arithmetic operations finish in one cycle. SLL and SRL use a
// 1-bit-per-cycle shifter, so a start/busy/done handshake is provided.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Single-cycle operations. Returns {zero, result}. Branch compares
    // override the usual zero-result flag. Undefined codes give 0 / Zero=1.
    function automatic logic [WIDTH:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sum;
        logic signed [WIDTH-1:0] diff;
        logic        [WIDTH-1:0] res;
        logic                    zf;
        sum  = $signed(a) + $signed(b);
        diff = $signed(a) - $signed(b);
        res  = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_ADD:  res = sum;
            OP_SUB:  res = diff;
            OP_LUI:  res = {b[15:0], {(WIDTH-16){1'b0}}};
            OP_BEQ:  res = diff;
            OP_BNE:  res = diff;
            default: res = '0;
        endcase
        zf = (res == '0);
        if (op == OP_BEQ) zf = (a == b);
        if (op == OP_BNE) zf = (a != b);
        return {zf, res};
    endfunction

    // Stage p0: shifter working registers (operand, remaining count, direction)
    logic [WIDTH-1:0] work_p0;
    logic [4:0]       cnt_p0;
    logic             left_p0;

    // Stage p1: architectural outputs
    logic [WIDTH-1:0] result_p1;
    logic             zero_p1;
    logic             vld_p1;

    logic             is_shift;
    logic             load_shift;
    logic             shift_step;
    logic             finish_single;
    logic             finish_shift;
    logic [WIDTH:0]   eval_p0;

    assign is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign eval_p0  = alu_eval(ALUOperation, A, B);

    // State register; reset abandons any shift in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt     = state;
        load_shift    = 1'b0;
        shift_step    = 1'b0;
        finish_single = 1'b0;
        finish_shift  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift) begin
                        load_shift = 1'b1;
                        state_nxt  = SHIFT;
                    end else begin
                        finish_single = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_p0 != 5'd0) begin
                    shift_step = 1'b1;
                end else begin
                    finish_shift = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shifter: capture operands at accept, then move one bit per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work_p0 <= '0;
            cnt_p0  <= '0;
            left_p0 <= 1'b0;
        end else if (load_shift) begin
            work_p0 <= B;
            cnt_p0  <= shamt;
            left_p0 <= (ALUOperation == OP_SLL);
        end else if (shift_step) begin
            work_p0 <= left_p0 ? {work_p0[WIDTH-2:0], 1'b0} : {1'b0, work_p0[WIDTH-1:1]};
            cnt_p0  <= cnt_p0 - 5'd1;
        end
    end

    // Output registers change only on the edge that raises done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= finish_single | finish_shift;
            if (finish_single) begin
                result_p1 <= eval_p0[WIDTH-1:0];
                zero_p1   <= eval_p0[WIDTH];
            end else if (finish_shift) begin
                result_p1 <= work_p0;
                zero_p1   <= (work_p0 == '0);
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = vld_p1;
    assign ALUResult = result_p1;
    assign Zero      = zero_p1;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: a scoreboard queue holds expected result, flag and
// completion cycle for every accepted request; a monitor pops on each done.
module tb_multicycle_alu;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ALUOperation = 4'b0000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour, written directly from the opcode table
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        e.cyc = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = ~(a | b);
            4'b0011: e.res = a + b;
            4'b0100: e.res = a - b;
            4'b0101: e.res = {b[15:0], 16'h0000};
            4'b0111: e.res = b << sh;
            4'b1000: e.res = b >> sh;
            4'b1111: e.res = a - b;
            4'b1001: e.res = a - b;
            default: e.res = 32'h0;
        endcase
        if (op == 4'b1111)      e.zero = (a == b);
        else if (op == 4'b1001) e.zero = (a != b);
        else                    e.zero = (e.res == 32'h0);
        return e;
    endfunction

    // Scoreboard monitor: every done must match the oldest expectation, on time
    always @(negedge clk) begin
        if (sb.size() > 0 && !done && cyc > sb[0].cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL done_missing cyc=%0d required_by=%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done cyc=%0d result=%h", cyc, ALUResult);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (ALUResult !== e.res) begin
                    miscompares++;
                    $display("FAIL result cyc=%0d got=%h exp=%h", cyc, ALUResult, e.res);
                end
                vectors++;
                if (Zero !== e.zero) begin
                    miscompares++;
                    $display("FAIL zero cyc=%0d got=%b exp=%b", cyc, Zero, e.zero);
                end
                vectors++;
                if (cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    // Drive one request for one cycle (called at posedge+1); optionally expect it
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit expect_done);
        exp_t e;
        ALUOperation = op;
        A = a;
        B = b;
        shamt = sh;
        start = 1'b1;
        if (expect_done) begin
            e = model(op, a, b, sh);
            e.cyc = cyc + (((op == 4'b0111) || (op == 4'b1000)) ? int'(sh) + 2 : 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        ALUOperation = 4'b0011;
        A = 32'h1;
        B = 32'h1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++;
        if (ALUResult !== 32'h0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
        vectors++;
        if (Zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got=%b exp=0", Zero); end
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        issue(4'b0011, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL add_busy got=%b exp=0", busy); end
        issue(4'b0100, 32'h1234, 32'h1234, 5'd0, 1'b1);
        issue(4'b0100, 32'h0, 32'h1, 5'd0, 1'b1);
        issue(4'b0011, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_logic_branch();
        issue(4'b1111, 32'h5, 32'h5, 5'd0, 1'b1);
        issue(4'b1001, 32'h5, 32'h5, 5'd0, 1'b1);
        issue(4'b1001, 32'h5, 32'h6, 5'd0, 1'b1);
        issue(4'b1111, 32'h5, 32'h6, 5'd0, 1'b1);
        issue(4'b0101, 32'h0, 32'h0000ABCD, 5'd0, 1'b1);
        issue(4'b1010, 32'h3, 32'h4, 5'd0, 1'b1);
        issue(4'b0110, 32'h3, 32'h4, 5'd0, 1'b1);
        issue(4'b1110, 32'h3, 32'h4, 5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            issue(4'b0000, ra, rb, 5'd0, 1'b1);
            issue(4'b0001, ra, rb, 5'd0, 1'b1);
            issue(4'b0010, ra, rb, 5'd0, 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Shift with busy checked in every cycle from 1 to shamt+1, clear after
    task automatic run_shift(input logic [3:0] op, input logic [31:0] b, input logic [4:0] sh);
        issue(op, 32'h0, b, sh, 1'b1);
        for (int k = 1; k <= int'(sh) + 1; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL shift_busy k=%0d got=%b exp=1", k, busy); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL shift_busy_end got=%b exp=0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_shift();
        run_shift(4'b0111, 32'h1, 5'd31);
        run_shift(4'b1000, 32'h80000000, 5'd4);
        run_shift(4'b0111, 32'hA5, 5'd0);
        run_shift(4'b1000, 32'hF0F0_1234, 5'd13);
        run_shift(4'b0111, 32'h8000_0000, 5'd1);
    endtask

    // Requests while busy are dropped; a request in the done cycle is taken
    task automatic test_back_to_back();
        issue(4'b0111, 32'h0, 32'h1, 5'd8, 1'b1);
        repeat (7) begin
            start = 1'b1;
            ALUOperation = 4'b0011;
            A = $urandom;
            B = $urandom;
            shamt = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(4'b0011, 32'h2, 32'h3, 5'd0, 1'b1);
        issue(4'b1000, 32'h0, 32'h0000_FF00, 5'd3, 1'b1);
        issue(4'b0011, 32'h9, 32'h9, 5'd0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midshift();
        issue(4'b0011, 32'h5, 32'h0, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        issue(4'b1000, 32'h0, 32'hDEAD_BEEF, 5'd10, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        vectors++;
        if (ALUResult !== 32'h0) begin miscompares++; $display("FAIL midrst_result got=%h exp=0", ALUResult); end
        vectors++;
        if (Zero !== 1'b0) begin miscompares++; $display("FAIL midrst_zero got=%b exp=0", Zero); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        issue(4'b0000, 32'hF0, 32'h3C, 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic_branch();
        test_shift();
        test_back_to_back();
        test_reset_midshift();
        for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
